// File: rtl/mandelbrot_pixel_engine.sv
// Iterative Mandelbrot/Julia pixel engine: one z <- z^2 + c step per clock in
// signed 2.(WIDTH-2) fixed point, reporting the iteration count at escape or limit.
module mandelbrot_pixel_engine #(
  parameter int WIDTH      = 8,
  parameter int ITER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_pr,
  input  logic [WIDTH-1:0]      in_pi,
  input  logic [ITER_WIDTH-1:0] in_max_iter,
  input  logic                  julia,
  input  logic [WIDTH-1:0]      julia_cr,
  input  logic [WIDTH-1:0]      julia_ci,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ITER_WIDTH-1:0] out_iter,
  output logic                  out_escaped,
  output logic [1:0]            state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; the producer holds its payload steady until that edge.

  localparam int FRAC = WIDTH - 2;
  localparam int PW   = 2 * WIDTH;
  localparam int EW   = 2 * WIDTH + 2;

  localparam logic signed [EW-1:0] ZMAX     = EW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [EW-1:0] ZMIN     = EW'(-(2 ** (WIDTH - 1)));
  localparam logic        [PW:0]   SIZE_LIM = (PW + 1)'(4) << FRAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] zr_q, zi_q, cr_q, ci_q;
  logic [ITER_WIDTH-1:0]   count_q, max_q, iter_q;
  logic                    esc_q;

  logic signed [PW-1:0] m1, m2, m3;
  logic signed [EW-1:0] m1_x, m2_x, m3_x, cr_x, ci_x;
  logic signed [EW-1:0] re_sh, im_sh, zr_next, zi_next;
  logic        [PW:0]   mag, mag_sh;
  logic                 size_hit, overflow, escape;
  logic [ITER_WIDTH-1:0] count_inc;
  logic                 last_step;

  // Full-precision step; extended width keeps the overflow test exact.
  always_comb begin
    m1        = PW'(zr_q) * PW'(zr_q);
    m2        = PW'(zi_q) * PW'(zi_q);
    m3        = PW'(zr_q) * PW'(zi_q);
    m1_x      = EW'(m1);
    m2_x      = EW'(m2);
    m3_x      = EW'(m3);
    cr_x      = EW'(cr_q);
    ci_x      = EW'(ci_q);
    re_sh     = (m1_x - m2_x) >>> FRAC;
    im_sh     = (m3_x <<< 1) >>> FRAC;
    zr_next   = re_sh + cr_x;
    zi_next   = im_sh + ci_x;
    mag       = $unsigned((PW + 1)'(m1)) + $unsigned((PW + 1)'(m2));
    mag_sh    = mag >> FRAC;
    size_hit  = mag_sh > SIZE_LIM;
    overflow  = (zr_next > ZMAX) || (zr_next < ZMIN) ||
                (zi_next > ZMAX) || (zi_next < ZMIN);
    escape    = size_hit || overflow;
    count_inc = count_q + 1'b1;
    last_step = (count_inc == max_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (in_max_iter == '0) ? DONE : ITER;
      ITER: if (escape || last_step) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      zr_q    <= '0;
      zi_q    <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      count_q <= '0;
      max_q   <= '0;
      iter_q  <= '0;
      esc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            max_q   <= in_max_iter;
            count_q <= '0;
            iter_q  <= '0;
            esc_q   <= 1'b0;
            if (julia) begin
              zr_q <= $signed(in_pr);
              zi_q <= $signed(in_pi);
              cr_q <= $signed(julia_cr);
              ci_q <= $signed(julia_ci);
            end else begin
              zr_q <= '0;
              zi_q <= '0;
              cr_q <= $signed(in_pr);
              ci_q <= $signed(in_pi);
            end
          end
        end
        ITER: begin
          if (escape) begin
            // z is left at the last in-range value.
            iter_q <= count_q;
            esc_q  <= 1'b1;
          end else begin
            zr_q    <= zr_next[WIDTH-1:0];
            zi_q    <= zi_next[WIDTH-1:0];
            count_q <= count_inc;
            if (last_step) begin
              iter_q <= max_q;
              esc_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_iter    = iter_q;
  assign out_escaped = esc_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mandelbrot_pixel_engine.sv
// Directed bench for mandelbrot_pixel_engine: a driver issues jobs and queues the
// expected result; a monitor checks each result, its latency and its stability.
module tb_mandelbrot_pixel_engine;

  localparam int W   = 8;
  localparam int IW  = 8;
  localparam int EXW = 16 + 1 + IW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_pr, in_pi;
  logic [IW-1:0] in_max_iter;
  logic          julia;
  logic [W-1:0]  julia_cr, julia_ci;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_iter;
  logic          out_escaped;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected entry: {latency[15:0], escaped, iter}
  logic [EXW-1:0] exp_q[$];
  int             acc_q[$];

  mandelbrot_pixel_engine #(.WIDTH(W), .ITER_WIDTH(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pr      (in_pr),
    .in_pi      (in_pi),
    .in_max_iter(in_max_iter),
    .julia      (julia),
    .julia_cr   (julia_cr),
    .julia_ci   (julia_ci),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_iter   (out_iter),
    .out_escaped(out_escaped),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  logic          seen = 1'b0;
  logic [IW-1:0] held_iter;
  logic          held_esc;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          logic [EXW-1:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("out_iter", int'(out_iter), int'(e[IW-1:0]));
          chk("out_escaped", int'(out_escaped), int'(e[IW]));
          chk("latency", cyc - a, int'(e[EXW-1:IW+1]));
        end
        seen      = 1'b1;
        held_iter = out_iter;
        held_esc  = out_escaped;
      end else begin
        chk("hold_iter", int'(out_iter), int'(held_iter));
        chk("hold_escaped", int'(out_escaped), int'(held_esc));
        chk("hold_in_ready", int'(in_ready), 0);
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic scramble();
    in_pr       = W'($urandom_range(0, 255));
    in_pi       = W'($urandom_range(0, 255));
    in_max_iter = IW'($urandom_range(0, 255));
    julia       = 1'($urandom_range(0, 1));
    julia_cr    = W'($urandom_range(0, 255));
    julia_ci    = W'($urandom_range(0, 255));
  endtask

  // Driver: offer one job, then (if tracked) consume its result after `hold` stalled cycles.
  task automatic run_job(input logic [W-1:0] pr, input logic [W-1:0] pi,
                         input logic [IW-1:0] mi, input logic jul,
                         input logic [W-1:0] jcr, input logic [W-1:0] jci,
                         input int e_iter, input int e_esc, input int e_lat,
                         input int hold, input bit track);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_pr = pr; in_pi = pi; in_max_iter = mi;
    julia = jul; julia_cr = jcr; julia_ci = jci;
    in_valid = 1'b1;
    if (track) exp_q.push_back({16'(e_lat), 1'(e_esc), IW'(e_iter)});
    @(posedge clk);
    #1;
    if (track) acc_q.push_back(cyc);
    in_valid = 1'b0;
    scramble();
    if (!track) return;
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      scramble();
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_handshake_in_ready", int'(in_ready), 1);
    chk("post_handshake_out_valid", int'(out_valid), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pr = '0; in_pi = '0; in_max_iter = '0;
    julia = 1'b0; julia_cr = '0; julia_ci = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_iter", int'(out_iter), 0);
    chk("rst_out_escaped", int'(out_escaped), 0);
    rst_n = 1'b1;

    // Mandelbrot c=0: runs to the limit
    run_job(8'd0, 8'd0, 8'd20, 1'b0, 8'h11, 8'h22, 20, 0, 20, 0, 1'b1);
    // c=-2: overflow on step 1
    run_job(8'h80, 8'd0, 8'd20, 1'b0, 8'd0, 8'd0, 1, 1, 2, 0, 1'b1);
    // escape wins over limit on the same step
    run_job(8'h80, 8'd0, 8'd2, 1'b0, 8'd0, 8'd0, 1, 1, 2, 0, 1'b1);
    // c=0.5: z = 32,48,68,104 then overflow; stalled 10 cycles
    run_job(8'd32, 8'd0, 8'd50, 1'b0, 8'd0, 8'd0, 4, 1, 5, 10, 1'b1);
    // Julia c=0, z0=0.5: decays to 0, hits limit
    run_job(8'd32, 8'd0, 8'd10, 1'b1, 8'd0, 8'd0, 10, 0, 10, 0, 1'b1);
    // zero limit: straight to DONE
    run_job(8'd32, 8'd0, 8'd0, 1'b1, 8'd0, 8'd0, 0, 0, 0, 3, 1'b1);
    // limit of one
    run_job(8'd0, 8'd0, 8'd1, 1'b0, 8'd0, 8'd0, 1, 0, 1, 0, 1'b1);
    // Julia z0=(-2,0.125), c=(-2,0): |z|^2 > 4 with no overflow
    run_job(8'h80, 8'd8, 8'd9, 1'b1, 8'h80, 8'd0, 0, 1, 1, 0, 1'b1);
    // full-range limit, no count wrap
    run_job(8'd0, 8'd0, 8'd255, 1'b0, 8'd0, 8'd0, 255, 0, 255, 0, 1'b1);

    // Reset mid-ITER after three steps, job discarded
    run_job(8'd0, 8'd0, 8'd20, 1'b0, 8'd0, 8'd0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_iter", int'(out_iter), 0);
    chk("midrst_out_escaped", int'(out_escaped), 0);
    chk("midrst_state", int'(state_dbg), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(8'd32, 8'd0, 8'd50, 1'b0, 8'd0, 8'd0, 4, 1, 5, 2, 1'b1);

    repeat (5) @(negedge clk);
    chk("leftover_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mandelbrot_pixel_engine.md
MANDELBROT_PIXEL_ENGINE -- requirements
Module: mandelbrot_pixel_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8: coordinate width; fixed-point format 2.(WIDTH-2) signed, 1.0 = 2^(WIDTH-2).
REQ-002 SHALL have parameter ITER_WIDTH, default 8: width of iteration limit and count.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  pixel job offered.
REQ-006 in_ready  output  1  engine can accept a job.
REQ-007 in_pr, in_pi  input  WIDTH each  pixel coordinate, signed 2.(WIDTH-2).
REQ-008 in_max_iter  input  ITER_WIDTH  iteration limit for this job.
REQ-009 julia  input  1  mode, sampled at accept: 0 Mandelbrot, 1 Julia.
REQ-010 julia_cr, julia_ci  input  WIDTH each  Julia constant, sampled at accept.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out_iter  output  ITER_WIDTH  iteration count at termination.
REQ-014 out_escaped  output  1  1 = escaped/overflowed, 0 = limit reached.

Function
REQ-015 SHALL implement FSM states IDLE, ITER, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 Accept on edge with in_valid && in_ready: latch max_iter, count<=0; Mandelbrot: z<=0, c<=(in_pr,in_pi); Julia: z<=(in_pr,in_pi), c<=(julia_cr,julia_ci).
REQ-017 On accept with in_max_iter==0 SHALL go directly to DONE, out_iter=0, out_escaped=0; else go to ITER.
REQ-018 Each ITER cycle SHALL evaluate one step on current z, full precision: m1=zr*zr, m2=zi*zi, m3=zr*zi (2*WIDTH signed).
REQ-019 Next values: zr'=((m1-m2)>>>(WIDTH-2))+cr; zi'=((2*m3)>>>(WIDTH-2))+ci; arithmetic shift = floor truncation.
REQ-020 size = ((m1+m2)>>(WIDTH-2)) > 4*2^(WIDTH-2), unsigned compare, no wrap.
REQ-021 overflow = zr' or zi' outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] before truncation to WIDTH bits.
REQ-022 If size || overflow: go DONE, out_iter=count, out_escaped=1, z not updated.
REQ-023 Else z<=(zr',zi'), count<=count+1; if count+1==max_iter go DONE with out_iter=max_iter, out_escaped=0.
REQ-024 Latency: escape at count k -> out_valid high after edge k+1 following accept edge; limit reached -> after edge max_iter following accept.
REQ-025 In DONE, out_iter/out_escaped SHALL stay stable until out_valid && out_ready edge, then return to IDLE; no new job accepted in that same edge.
REQ-026 Inputs other than in_valid ignored outside the accept edge; changes during ITER SHALL not affect the job.
REQ-027 count SHALL never wrap: limit check precedes increment past max_iter.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, z=0, c=0, count=0, out_iter=0, out_escaped=0, out_valid=0, in_ready=1, including mid-ITER or DONE (job discarded).
REQ-029 First accept possible on first rising edge after rst_n deasserts.

Verification (WIDTH=8, ITER_WIDTH=8, 1.0=64)
REQ-030 Mandelbrot c=(0,0), max_iter=20 -> out_valid 20 edges after accept, out_iter=20, out_escaped=0.
REQ-031 Mandelbrot c=(-128,0) -> step0 z=-128, step1 overflow (zr'=128) -> out_iter=1, out_escaped=1, out_valid after edge 2.
REQ-032 Mandelbrot c=(32,0), max_iter=50 -> z sequence 32,48,68,104, overflow at step4 (zr'=201) -> out_iter=4, out_escaped=1.
REQ-033 Julia=1, julia_c=(0,0), pixel (32,0), max_iter=10 -> z 16,4,0,... -> out_iter=10, out_escaped=0; in_max_iter=0 -> DONE next edge, out_iter=0, out_escaped=0.
REQ-034 Backpressure: out_ready held 0 for 10 cycles -> out_valid, out_iter, out_escaped stable, in_ready=0; in_valid ignored until handshake.
REQ-035 rst_n pulsed low mid-ITER (count=3) -> outputs at reset values immediately, next accepted job produces correct fresh result.
